// File: rtl/game_referee.sv
// game_referee: match controller for the pong ball/paddle FSM; owns scores, BCD countdown and winner.
// Ports: clk/rst (async, active-high) | start (button level, rising edge used)
//        miss1/miss2 (player missed, level) | stop (1 = hold ball centred)
//        min/sec (BCD countdown) | score1/score2 | state (00 IDLE,01 SERVE,10 PLAY,11 OVER)
//        winner (00 none,01 p1,10 p2,11 draw)
// Build option: define REFEREE_SUDDEN_DEATH_EN to let a tied match continue past 00 until the next point.
module game_referee #(
    parameter int CLK_PER_SEC  = 50_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int SERVE_DELAY  = 25_000_000,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       miss1,
    input  logic       miss2,
    output logic       stop,
    output logic [3:0] min,
    output logic [3:0] sec,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] state,
    output logic [1:0] winner
);
    localparam int PW = CLK_PER_SEC > 1 ? $clog2(CLK_PER_SEC) : 1;
    localparam int DW = SERVE_DELAY > 1 ? $clog2(SERVE_DELAY) : 1;
    localparam logic [3:0] MIN0 = 4'(GAME_SECONDS / 10);
    localparam logic [3:0] SEC0 = 4'(GAME_SECONDS % 10);
    localparam logic [3:0] WIN  = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, OVER = 2'b11} state_t;

    state_t        state_q, state_d;
    logic          start_q, m1_q, m2_q, stop_q, stop_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [3:0]    min_q, min_d, sec_q, sec_d, s1_q, s1_d, s2_q, s2_d;
    logic [1:0]    win_q, win_d;
    logic          start_rise, r1, r2, p1, p2, tick, zero, expire, win_hit, over;

    always_comb begin
        start_rise = start & ~start_q;
        // Misses are edge-qualified so a level held across a serve is scored only once.
        r1 = miss1 & ~m1_q;
        r2 = miss2 & ~m2_q;
        p1 = r2 & ~r1;
        p2 = r1 & ~r2;
        tick = pre_q == PW'(CLK_PER_SEC - 1);
        zero = min_q == 4'd0 && sec_q == 4'd0;
        expire = 1'b0;
        win_hit = 1'b0;
        over = 1'b0;
        state_d = state_q;
        pre_d = pre_q;
        dly_d = dly_q;
        min_d = min_q;
        sec_d = sec_q;
        s1_d = s1_q;
        s2_d = s2_q;
        win_d = win_q;
        case (state_q)
            IDLE, OVER: if (start_rise) begin
                state_d = SERVE;
                dly_d = '0;
                s1_d = '0;
                s2_d = '0;
                min_d = MIN0;
                sec_d = SEC0;
                win_d = 2'b00;
            end
            SERVE: if (dly_q == DW'(SERVE_DELAY - 1)) begin
                state_d = PLAY;
                pre_d = '0;
            end else dly_d = dly_q + 1'b1;
            PLAY: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (p1) s1_d = s1_q == 4'd15 ? 4'd15 : s1_q + 4'd1;
                if (p2) s2_d = s2_q == 4'd15 ? 4'd15 : s2_q + 4'd1;
                if (tick && !zero) begin
                    sec_d = sec_q == 4'd0 ? 4'd9 : sec_q - 4'd1;
                    min_d = sec_q == 4'd0 ? min_q - 4'd1 : min_q;
                end
                expire = tick && !zero && min_d == 4'd0 && sec_d == 4'd0;
                win_hit = (p1 && s1_d == WIN) || (p2 && s2_d == WIN);
`ifdef REFEREE_SUDDEN_DEATH_EN
                // A tie at 00 keeps playing; the next single point decides.
                over = win_hit || (expire && s1_d != s2_d) || (zero && (p1 || p2));
`else
                over = win_hit || expire;
`endif
                if (over) begin
                    state_d = OVER;
                    win_d = s1_d > s2_d ? 2'b01 : s2_d > s1_d ? 2'b10 : 2'b11;
                end else if (r1 || r2) begin
                    state_d = SERVE;
                    dly_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        stop_d = state_d != PLAY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            m1_q <= 1'b0;
            m2_q <= 1'b0;
            stop_q <= 1'b1;
            pre_q <= '0;
            dly_q <= '0;
            min_q <= MIN0;
            sec_q <= SEC0;
            s1_q <= '0;
            s2_q <= '0;
            win_q <= 2'b00;
        end else begin
            state_q <= state_d;
            start_q <= start;
            m1_q <= miss1;
            m2_q <= miss2;
            stop_q <= stop_d;
            pre_q <= pre_d;
            dly_q <= dly_d;
            min_q <= min_d;
            sec_q <= sec_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            win_q <= win_d;
        end
    end

    assign stop = stop_q;
    assign min = min_q;
    assign sec = sec_q;
    assign score1 = s1_q;
    assign score2 = s2_q;
    assign state = state_q;
    assign winner = win_q;
endmodule
